// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM states, lane masks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    // RV32 funct3 width codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Right-justified byte-lane masks, shifted into place by the byte offset
    localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_RMW_WR,
        S_ST_WR,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane steering: load extraction with sign/zero extension, and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  lane_shift;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    // Shift the addressed lane down to bit 0, then extend according to the width code
    always_comb begin
        lane_shift = {addr_lo, 3'b000};
        shifted    = word >> lane_shift;
        load_data  = word;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    // Replace only the addressed byte/half of the old word with the low bits of the store data
    always_comb begin
        lane_mask  = ((funct3 == F3_H) ? LANE_MASK_H : LANE_MASK_B) << lane_shift;
        merge_data = (word & ~lane_mask) | ((wdata << lane_shift) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit bridging the MEM stage to a word-ported memory; optional range check via LSU_RANGE_CHECK_EN.
// Latency: acceptance to resp_valid is 1 cycle for errors, 2 for loads/SW, 3 for SB/SH (read-modify-write).
// Backpressure: req_ready is high only in IDLE; the one-cycle response cannot be stalled.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 65536,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_readData
);

    // The lane logic is written for a 32-bit word; reject anything else at elaboration
    if (DATA_W != 32 || MEM_BYTES < 4) begin : g_bad_cfg
        $error("load_store_unit: unsupported DATA_W or MEM_BYTES");
    end

    lsu_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_err;
    logic [ADDR_W-1:0] aligned_q;
    logic [DATA_W-1:0] align_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    assign aligned_q = {addr_q[ADDR_W-1:2], 2'b00};

    // Classify the incoming request: illegal width codes and misaligned addresses never reach memory
    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            F3_B:    req_err = 1'b0;
            F3_H:    req_err = req_addr[0];
            F3_W:    req_err = (req_addr[1:0] != 2'b00);
            F3_BU:   req_err = req_write;
            F3_HU:   req_err = req_write | req_addr[0];
            default: req_err = 1'b1;
        endcase
`ifdef LSU_RANGE_CHECK_EN
        // Last byte of the aligned word must lie inside the memory; 64-bit sum avoids wrap
        if ((64'({req_addr[ADDR_W-1:2], 2'b00}) + 64'd3) >= 64'(MEM_BYTES)) begin
            req_err = 1'b1;
        end
`endif
    end

    lsu_align u_align (
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .word       (align_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state, request latching and state-decoded memory port
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        merge_d       = merge_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_MemRead   = 1'b0;
        mem_MemWrite  = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        align_word    = merge_q;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = S_ST_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                mem_MemRead = 1'b1;
                mem_address = aligned_q;
                align_word  = mem_readData;
                rdata_d     = load_data;
                state_d     = S_RESP;
            end
            S_RMW_RD: begin
                mem_MemRead = 1'b1;
                mem_address = aligned_q;
                merge_d     = mem_readData;
                state_d     = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_MemWrite  = 1'b1;
                mem_address   = aligned_q;
                mem_writeData = merge_data;
                state_d       = S_RESP;
            end
            S_ST_WR: begin
                mem_MemWrite  = 1'b1;
                mem_address   = aligned_q;
                mem_writeData = wdata_q;
                state_d       = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // State and request registers; async reset aborts any in-flight access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // write_q is retained for debug visibility of the in-flight request type
    logic unused_ok;
    assign unused_ok = write_q;

endmodule
